// File: rtl/path_walker_if.sv
// Handshake and data bundle between a path_walker and its controller/step consumer.
// The slave modport is the walker; the master drives start/config and accepts steps.
interface path_walker_if;
  logic       start;
  logic [8:0] subset_cells;
  logic [8:0] path_in;
  logic [3:0] source;
  logic [3:0] destination;
  logic       step_ready;
  logic       step_valid;
  logic [3:0] step_cell;
  logic [1:0] step_dir;
  logic [3:0] step_count;
  logic       busy;
  logic       done;
  logic [1:0] error;

  modport slave (
    input  start, subset_cells, path_in, source, destination, step_ready,
    output step_valid, step_cell, step_dir, step_count, busy, done, error
  );

  modport master (
    output start, subset_cells, path_in, source, destination, step_ready,
    input  step_valid, step_cell, step_dir, step_count, busy, done, error
  );
endinterface

// File: rtl/path_walker.sv
// Walks a 3x3 path mask from source to destination, presenting one step per valid/ready handshake.
// Latency: first step valid 3 cycles after start; 2 cycles per later step; EMIT stalls while step_ready=0.
module path_walker (
  input  logic            clk,
  input  logic            reset,
  path_walker_if.slave    bus
);
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WALK, S_EMIT, S_FIN} state_t;

  state_t     r_state;
  logic [8:0] r_subset;
  logic [8:0] r_path;
  logic [3:0] r_src;
  logic [3:0] r_dst;
  logic [3:0] r_cur;
  logic [8:0] r_visited;
  logic       r_step_valid;
  logic [3:0] r_step_cell;
  logic [1:0] r_step_dir;
  logic [3:0] r_step_count;
  logic       r_busy;
  logic       r_done;
  logic [1:0] r_error;

  logic [8:0] w_free;
  logic [8:0] w_src_oh;
  logic [8:0] w_dst_oh;
  logic [3:0] w_up, w_rt, w_dn, w_lf;
  logic       w_up_ok, w_rt_ok, w_dn_ok, w_lf_ok;
  logic       w_found;
  logic [3:0] w_next_cell;
  logic [1:0] w_next_dir;

  assign w_free   = r_path & ~r_visited;
  assign w_src_oh = 9'd1 << r_src;
  assign w_dst_oh = 9'd1 << r_dst;
  assign w_up     = r_cur - 4'd3;
  assign w_rt     = r_cur + 4'd1;
  assign w_dn     = r_cur + 4'd3;
  assign w_lf     = r_cur - 4'd1;

  // Column edges stop right/left moves from wrapping into the adjacent row.
  assign w_up_ok = (r_cur >= 4'd3);
  assign w_dn_ok = (r_cur <= 4'd5);
  assign w_rt_ok = (r_cur != 4'd2) && (r_cur != 4'd5) && (r_cur != 4'd8);
  assign w_lf_ok = (r_cur != 4'd0) && (r_cur != 4'd3) && (r_cur != 4'd6);

  always_comb begin
    w_found     = 1'b0;
    w_next_cell = 4'd0;
    w_next_dir  = 2'd0;
    if (w_up_ok && w_free[w_up]) begin
      w_found = 1'b1; w_next_cell = w_up; w_next_dir = 2'd0;
    end else if (w_rt_ok && w_free[w_rt]) begin
      w_found = 1'b1; w_next_cell = w_rt; w_next_dir = 2'd1;
    end else if (w_dn_ok && w_free[w_dn]) begin
      w_found = 1'b1; w_next_cell = w_dn; w_next_dir = 2'd2;
    end else if (w_lf_ok && w_free[w_lf]) begin
      w_found = 1'b1; w_next_cell = w_lf; w_next_dir = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_subset     <= 9'd0;
      r_path       <= 9'd0;
      r_src        <= 4'd0;
      r_dst        <= 4'd0;
      r_cur        <= 4'd0;
      r_visited    <= 9'd0;
      r_step_valid <= 1'b0;
      r_step_cell  <= 4'd0;
      r_step_dir   <= 2'd0;
      r_step_count <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_subset     <= bus.subset_cells;
            r_path       <= bus.path_in;
            r_src        <= bus.source;
            r_dst        <= bus.destination;
            r_step_count <= 4'd0;
            r_error      <= 2'd0;
            r_busy       <= 1'b1;
            r_state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_src > 4'd8 || r_dst > 4'd8) begin
            r_error <= 2'd1;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if ((r_path & w_src_oh) == 9'd0 || (r_path & w_dst_oh) == 9'd0 ||
                       (r_path & ~r_subset) != 9'd0) begin
            r_error <= 2'd2;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_cur     <= r_src;
            r_visited <= w_src_oh;
            if (r_src == r_dst) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_WALK;
            end
          end
        end
        S_WALK: begin
          if (w_found) begin
            r_step_cell  <= w_next_cell;
            r_step_dir   <= w_next_dir;
            r_step_valid <= 1'b1;
            r_state      <= S_EMIT;
          end else begin
            r_error <= 2'd3;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_EMIT: begin
          if (bus.step_ready) begin
            r_step_valid <= 1'b0;
            r_cur        <= r_step_cell;
            r_visited    <= r_visited | (9'd1 << r_step_cell);
            r_step_count <= r_step_count + 4'd1;
            if (r_step_cell == r_dst) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_WALK;
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.step_valid = r_step_valid;
  assign bus.step_cell  = r_step_cell;
  assign bus.step_dir   = r_step_dir;
  assign bus.step_count = r_step_count;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
endmodule

// File: tb/tb_path_walker.sv
// Directed bench for path_walker: walks, error codes, backpressure and mid-walk reset.
module tb_path_walker;
  logic clk = 1'b0;
  logic reset;
  path_walker_if bus ();

  path_walker u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] got_cell [8];
  logic [1:0] got_dir  [8];
  int         n_steps;
  int         first_vld;
  int         done_pulses;
  int         done_cyc;
  int         done_err;
  int         done_cnt;
  int         timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a walk with step_ready=1, scrambles the inputs afterwards, and records every step.
  task automatic run_walk(input logic [8:0] sub, input logic [8:0] pth,
                          input logic [3:0] src, input logic [3:0] dst);
    int after;
    n_steps = 0; first_vld = -1; done_pulses = 0; done_cyc = -1;
    done_err = 0; done_cnt = 0; timed_out = 1; after = -1;
    bus.subset_cells = sub; bus.path_in = pth; bus.source = src; bus.destination = dst;
    bus.step_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.subset_cells = ~sub; bus.path_in = 9'd0; bus.source = 4'd7; bus.destination = 4'd3;
    for (int cyc = 1; cyc < 80; cyc++) begin
      if (bus.step_valid && first_vld < 0) first_vld = cyc;
      if (bus.step_valid && bus.step_ready && n_steps < 8) begin
        got_cell[n_steps] = bus.step_cell;
        got_dir[n_steps]  = bus.step_dir;
        n_steps++;
      end
      if (bus.done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc; done_err = int'(bus.error); done_cnt = int'(bus.step_count); after = 0;
        end
      end
      if (after >= 0) begin
        if (after == 2) begin
          timed_out = 0;
          break;
        end
        after++;
      end
      tick();
    end
  endtask

  task automatic verify(input string tag, input int exp_n, input logic [15:0] exp_cells,
                        input logic [7:0] exp_dirs, input int exp_first, input int exp_done_cyc,
                        input int exp_err, input int exp_cnt);
    check({tag, ".timeout"}, timed_out, 0);
    check({tag, ".nsteps"}, n_steps, exp_n);
    for (int i = 0; i < exp_n && i < n_steps; i++) begin
      check($sformatf("%s.cell%0d", tag, i), 32'(got_cell[i]), 32'(exp_cells[4*i +: 4]));
      check($sformatf("%s.dir%0d", tag, i), 32'(got_dir[i]), 32'(exp_dirs[2*i +: 2]));
    end
    check({tag, ".first_vld"}, first_vld, exp_first);
    check({tag, ".done_cyc"}, done_cyc, exp_done_cyc);
    check({tag, ".done_pulses"}, done_pulses, 1);
    check({tag, ".err"}, done_err, exp_err);
    check({tag, ".cnt"}, done_cnt, exp_cnt);
    check({tag, ".busy_after"}, 32'(bus.busy), 0);
    check({tag, ".err_hold"}, 32'(bus.error), 32'(exp_err));
    check({tag, ".cnt_hold"}, 32'(bus.step_count), 32'(exp_cnt));
  endtask

  initial begin
    int waited;
    reset = 1'b1;
    bus.start = 1'b0; bus.subset_cells = 9'd0; bus.path_in = 9'd0;
    bus.source = 4'd0; bus.destination = 4'd0; bus.step_ready = 1'b0;
    tick(); tick();
    check("rst.valid", 32'(bus.step_valid), 0);
    check("rst.busy",  32'(bus.busy), 0);
    check("rst.done",  32'(bus.done), 0);
    check("rst.error", 32'(bus.error), 0);
    check("rst.count", 32'(bus.step_count), 0);
    reset = 1'b0;
    tick();

    // Main scenario: 0 -> 1 -> 2 -> 5 -> 8
    run_walk(9'h1FF, 9'b100100111, 4'd0, 4'd8);
    verify("walk08", 4, 16'h8521, 8'hA5, 3, 10, 0, 4);

    // Reverse corner using left and up moves: 8 -> 7 -> 6 -> 3 -> 0
    run_walk(9'h1FF, 9'b111001001, 4'd8, 4'd0);
    verify("walk80", 4, 16'h0367, 8'h0F, 3, 10, 0, 4);

    run_walk(9'h1FF, 9'b000010000, 4'd4, 4'd4);
    verify("same", 0, 16'h0, 8'h0, -1, 2, 0, 0);

    run_walk(9'h1FF, 9'b000000101, 4'd0, 4'd2);
    verify("broken0", 0, 16'h0, 8'h0, -1, 3, 3, 0);

    run_walk(9'h1FF, 9'b100000011, 4'd0, 4'd8);
    verify("broken1", 1, 16'h0001, 8'h01, 3, 5, 3, 1);

    run_walk(9'h1FF, 9'b100100111, 4'd0, 4'd9);
    verify("range", 0, 16'h0, 8'h0, -1, 2, 1, 0);

    run_walk(9'h0FF, 9'b100000001, 4'd0, 4'd8);
    verify("subset", 0, 16'h0, 8'h0, -1, 2, 2, 0);

    run_walk(9'h1FF, 9'b000000110, 4'd0, 4'd2);
    verify("srcbit", 0, 16'h0, 8'h0, -1, 2, 2, 0);

    // Backpressure on the first step
    bus.subset_cells = 9'h1FF; bus.path_in = 9'b100100111; bus.source = 4'd0; bus.destination = 4'd8;
    bus.step_ready = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("bp.walk_valid", 32'(bus.step_valid), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.valid%0d", i), 32'(bus.step_valid), 1);
      check($sformatf("bp.cell%0d", i), 32'(bus.step_cell), 1);
      check($sformatf("bp.dir%0d", i), 32'(bus.step_dir), 1);
      check($sformatf("bp.cnt%0d", i), 32'(bus.step_count), 0);
      tick();
    end
    bus.step_ready = 1'b1;
    tick();
    check("bp.cnt_after", 32'(bus.step_count), 1);
    check("bp.valid_after", 32'(bus.step_valid), 0);
    waited = 0;
    while (!bus.done && waited < 40) begin
      tick();
      waited++;
    end
    check("bp.done_seen", 32'(bus.done), 1);
    check("bp.err", 32'(bus.error), 0);
    check("bp.cnt", 32'(bus.step_count), 4);
    tick(); tick();

    // Reset during the second EMIT, with start asserted at the same edge
    bus.subset_cells = 9'h1FF; bus.path_in = 9'b100100111; bus.source = 4'd0; bus.destination = 4'd8;
    bus.step_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    check("rmid.valid", 32'(bus.step_valid), 1);
    check("rmid.cell", 32'(bus.step_cell), 2);
    check("rmid.cnt", 32'(bus.step_count), 1);
    reset = 1'b1; bus.start = 1'b1;
    tick();
    check("rmid.r_valid", 32'(bus.step_valid), 0);
    check("rmid.r_cell",  32'(bus.step_cell), 0);
    check("rmid.r_dir",   32'(bus.step_dir), 0);
    check("rmid.r_cnt",   32'(bus.step_count), 0);
    check("rmid.r_busy",  32'(bus.busy), 0);
    check("rmid.r_done",  32'(bus.done), 0);
    check("rmid.r_err",   32'(bus.error), 0);
    reset = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rmid.idle_done%0d", i), 32'(bus.done), 0);
      check($sformatf("rmid.idle_busy%0d", i), 32'(bus.busy), 0);
    end
    run_walk(9'h1FF, 9'b100100111, 4'd0, 4'd8);
    verify("rerun", 4, 16'h8521, 8'hA5, 3, 10, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
